// File: rtl/srm_pkg.sv
// srm_pkg: encodings shared by the Simple RISC Machine decoder, controller and
// datapath.
//   state_t      controller state encoding (also exported for debug)
//   NSEL_*       one-hot register select driven into the decoder
//   VSEL_*       register-file writeback source select
//   OPC_*/OP_*   instruction opcode [15:13] and op [12:11] fields
package srm_pkg;

   typedef enum logic [2:0] {
      S_WAIT      = 3'd0,
      S_DECODE    = 3'd1,
      S_WRITE_IMM = 3'd2,
      S_GET_A     = 3'd3,
      S_GET_B     = 3'd4,
      S_COMPUTE   = 3'd5,
      S_COMPARE   = 3'd6,
      S_WRITE_REG = 3'd7
   } state_t;

   // One-hot register select, as decoded by the instruction decoder.
   localparam logic [2:0] NSEL_NONE = 3'b000;
   localparam logic [2:0] NSEL_RN   = 3'b100;
   localparam logic [2:0] NSEL_RD   = 3'b010;
   localparam logic [2:0] NSEL_RM   = 3'b001;

   localparam logic [1:0] VSEL_C     = 2'b00;
   localparam logic [1:0] VSEL_PC    = 2'b01;
   localparam logic [1:0] VSEL_IMM   = 2'b10;
   localparam logic [1:0] VSEL_MDATA = 2'b11;

   localparam logic [2:0] OPC_MOV = 3'b110;
   localparam logic [2:0] OPC_ALU = 3'b101;

   // op field meaning depends on the opcode class.
   localparam logic [1:0] OP_MOV_REG = 2'b00;
   localparam logic [1:0] OP_MOV_IMM = 2'b10;
   localparam logic [1:0] OP_ADD     = 2'b00;
   localparam logic [1:0] OP_CMP     = 2'b01;
   localparam logic [1:0] OP_AND     = 2'b10;
   localparam logic [1:0] OP_MVN     = 2'b11;

   // Joins the two decoder fields into the 5-bit instruction class.
   function automatic logic [4:0] instr_class(input logic [2:0] opc, input logic [1:0] o);
      return {opc, o};
   endfunction

endpackage

// File: rtl/fsm_controller.sv
// fsm_controller: multi-cycle control FSM for the Simple RISC Machine
// datapath. Sequences one instruction at a time from the latched
// {opcode, op} and drives the decoder register select plus datapath controls.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   s                     start request (only looked at in WAIT)
//   opcode[2:0], op[1:0]  instruction fields from the decoder
//   w                     idle / ready for the next instruction
//   nsel[2:0]             one-hot register select back to the decoder
//   vsel[1:0]             writeback source select
//   write                 register-file write enable
//   loada/loadb/loadc/loads  datapath register loads
//   asel, bsel            ALU operand muxes (1 = zero / sximm5)
//   illegal               sticky unsupported-instruction flag
//   state_dbg             current FSM state
//
// Handshake: w is the ready signal and s the request. An instruction is
// accepted on any rising edge where w=1 and s=1; s is ignored at every other
// edge, and holding s high starts the next instruction on the first WAIT
// cycle.
module fsm_controller
   import srm_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       s,
   input  logic [2:0] opcode,
   input  logic [1:0] op,
   output logic       w,
   output logic [2:0] nsel,
   output logic [1:0] vsel,
   output logic       write,
   output logic       loada,
   output logic       loadb,
   output logic       loadc,
   output logic       loads,
   output logic       asel,
   output logic       bsel,
   output logic       illegal,
   output state_t     state_dbg
);

   state_t     state;
   state_t     next_state;
   logic [4:0] instr;
   logic       decode_bad;

   assign state_dbg = state;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_WAIT;
         instr   <= 5'd0;
         illegal <= 1'b0;
      end else begin
         state <= next_state;
         if (state == S_WAIT && s) begin
            // Capture the instruction once; the decoder may move on meanwhile.
            instr   <= instr_class(opcode, op);
            illegal <= 1'b0;
         end else if (decode_bad) begin
            illegal <= 1'b1;
         end
      end
   end

   always_comb begin
      next_state = state;
      decode_bad = 1'b0;
      w          = 1'b0;
      nsel       = NSEL_NONE;
      vsel       = VSEL_C;
      write      = 1'b0;
      loada      = 1'b0;
      loadb      = 1'b0;
      loadc      = 1'b0;
      loads      = 1'b0;
      asel       = 1'b0;
      bsel       = 1'b0;
      case (state)
         S_WAIT: begin
            w = 1'b1;
            if (s) next_state = S_DECODE;
         end
         S_DECODE: begin
            case (instr)
               {OPC_MOV, OP_MOV_IMM}: next_state = S_WRITE_IMM;
               {OPC_MOV, OP_MOV_REG}: next_state = S_GET_B;
               {OPC_ALU, OP_MVN}:     next_state = S_GET_B;
               {OPC_ALU, OP_ADD}:     next_state = S_GET_A;
               {OPC_ALU, OP_AND}:     next_state = S_GET_A;
               {OPC_ALU, OP_CMP}:     next_state = S_GET_A;
               default: begin
                  next_state = S_WAIT;
                  decode_bad = 1'b1;
               end
            endcase
         end
         S_WRITE_IMM: begin
            nsel       = NSEL_RN;
            vsel       = VSEL_IMM;
            write      = 1'b1;
            next_state = S_WAIT;
         end
         S_GET_A: begin
            nsel       = NSEL_RN;
            loada      = 1'b1;
            next_state = S_GET_B;
         end
         S_GET_B: begin
            nsel  = NSEL_RM;
            loadb = 1'b1;
            // CMP is the only instruction that reads B and stores flags.
            next_state = (instr == {OPC_ALU, OP_CMP}) ? S_COMPARE : S_COMPUTE;
         end
         S_COMPUTE: begin
            loadc      = 1'b1;
            // MOV Rd,Rm runs Rm through the ALU as 0 + Rm.
            asel       = (instr == {OPC_MOV, OP_MOV_REG});
            next_state = S_WRITE_REG;
         end
         S_COMPARE: begin
            loads      = 1'b1;
            next_state = S_WAIT;
         end
         S_WRITE_REG: begin
            nsel       = NSEL_RD;
            vsel       = VSEL_C;
            write      = 1'b1;
            next_state = S_WAIT;
         end
         default: next_state = S_WAIT;
      endcase
   end

endmodule

// File: tb/tb_fsm_controller.sv
module tb_fsm_controller;
   import srm_pkg::*;

   // Control vector {nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel, illegal}
   localparam int W = 13;
   localparam logic [W-1:0] E_DEC   = 13'b000_00_00000000;
   localparam logic [W-1:0] E_WIMM  = 13'b100_10_10000000;
   localparam logic [W-1:0] E_GA    = 13'b100_00_01000000;
   localparam logic [W-1:0] E_GB    = 13'b001_00_00100000;
   localparam logic [W-1:0] E_COMP  = 13'b000_00_00010000;
   localparam logic [W-1:0] E_COMPM = 13'b000_00_00010100;
   localparam logic [W-1:0] E_CMP   = 13'b000_00_00001000;
   localparam logic [W-1:0] E_WREG  = 13'b010_00_10000000;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       s = 1'b0;
   logic [2:0] opcode = 3'd0;
   logic [1:0] op = 2'd0;
   logic       w, write, loada, loadb, loadc, loads, asel, bsel, illegal;
   logic [2:0] nsel;
   logic [1:0] vsel;
   state_t     state_dbg;
   logic [W-1:0] ctrl;

   logic [W-1:0] exp_q[$];
   int n_checks = 0;
   int n_pass = 0;

   fsm_controller dut (
      .clk(clk), .reset_n(reset_n), .s(s), .opcode(opcode), .op(op),
      .w(w), .nsel(nsel), .vsel(vsel), .write(write),
      .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
      .asel(asel), .bsel(bsel), .illegal(illegal), .state_dbg(state_dbg)
   );

   assign ctrl = {nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel, illegal};

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: every busy (w=0) cycle must match the next expected vector.
   always @(negedge clk) begin
      if (reset_n && !w) begin
         if (exp_q.size() == 0) begin
            check("unexpected busy cycle", 16'(ctrl), 16'hffff);
         end else begin
            check("busy ctrl", 16'(ctrl), 16'(exp_q.pop_front()));
         end
      end
   end

   // driver tasks (all driving at posedge + 1)
   task automatic wait_ready(input string name);
      int n = 0;
      while (!w && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check({"ready ", name}, 16'(w), 16'd1);
   endtask

   task automatic issue(input logic [2:0] opc, input logic [1:0] o);
      opcode = opc;
      op     = o;
      s      = 1'b1;
      @(posedge clk); #1;
      s      = 1'b0;
   endtask

   task automatic finish_instr(input string name);
      wait_ready(name);
      check({"drain ", name}, 16'(exp_q.size()), 16'd0);
      exp_q.delete();
   endtask

   initial begin
      // reset state
      #1;
      check("reset w", 16'(w), 16'd1);
      check("reset ctrl", 16'(ctrl), 16'd0);
      #21 reset_n = 1'b1;
      @(posedge clk); #1;
      check("post-reset state", 16'(state_dbg), 16'(S_WAIT));
      check("post-reset ctrl", 16'(ctrl), 16'd0);
      check("post-reset w", 16'(w), 16'd1);

      // MOV imm: 2 busy cycles
      exp_q.push_back(E_DEC); exp_q.push_back(E_WIMM);
      issue(3'b110, 2'b10);
      finish_instr("mov imm");

      // ADD: 5 busy cycles
      exp_q.push_back(E_DEC); exp_q.push_back(E_GA); exp_q.push_back(E_GB);
      exp_q.push_back(E_COMP); exp_q.push_back(E_WREG);
      issue(3'b101, 2'b00);
      finish_instr("add");

      // AND, with opcode/op changing after acceptance
      exp_q.push_back(E_DEC); exp_q.push_back(E_GA); exp_q.push_back(E_GB);
      exp_q.push_back(E_COMP); exp_q.push_back(E_WREG);
      issue(3'b101, 2'b10);
      opcode = 3'b110; op = 2'b10;
      @(posedge clk); #1;
      opcode = 3'b111; op = 2'b01;
      finish_instr("and latched");

      // MOV reg: asel in COMPUTE
      exp_q.push_back(E_DEC); exp_q.push_back(E_GB);
      exp_q.push_back(E_COMPM); exp_q.push_back(E_WREG);
      issue(3'b110, 2'b00);
      finish_instr("mov reg");

      // CMP then MVN back-to-back with s held high
      exp_q.push_back(E_DEC); exp_q.push_back(E_GA); exp_q.push_back(E_GB);
      exp_q.push_back(E_CMP);
      exp_q.push_back(E_DEC); exp_q.push_back(E_GB);
      exp_q.push_back(E_COMP); exp_q.push_back(E_WREG);
      opcode = 3'b101; op = 2'b01; s = 1'b1;
      @(posedge clk); #1;
      opcode = 3'b101; op = 2'b11;
      repeat (4) begin @(posedge clk); #1; end
      check("cmp->mvn gap w", 16'(w), 16'd1);
      @(posedge clk); #1;
      check("mvn accepted first wait", 16'(w), 16'd0);
      s = 1'b0;
      finish_instr("cmp+mvn");

      // illegal: 1 busy cycle, sticky flag
      exp_q.push_back(E_DEC);
      issue(3'b111, 2'b00);
      finish_instr("illegal");
      check("illegal set", 16'(illegal), 16'd1);
      @(posedge clk); #1;
      check("illegal sticky", 16'(illegal), 16'd1);
      exp_q.push_back(E_DEC); exp_q.push_back(E_WIMM);
      issue(3'b110, 2'b10);
      finish_instr("after illegal");
      check("illegal cleared", 16'(illegal), 16'd0);

      // reset mid-GET_B of an ADD
      exp_q.push_back(E_DEC); exp_q.push_back(E_GA); exp_q.push_back(E_GB);
      issue(3'b101, 2'b00);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk); #1;
      reset_n = 1'b0;
      #1;
      check("async reset w", 16'(w), 16'd1);
      check("async reset loadb", 16'(loadb), 16'd0);
      check("async reset ctrl", 16'(ctrl), 16'd0);
      check("async reset queue", 16'(exp_q.size()), 16'd0);
      #1 reset_n = 1'b1;
      @(posedge clk); #1;
      check("after reset state", 16'(state_dbg), 16'(S_WAIT));
      check("after reset ctrl", 16'(ctrl), 16'd0);

      // report
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
